instr_fetch_unit: RTL

//   Downstream neighbour of the PC register. Takes each PC the PC register produces and

---
 rtl/mips_pkg.sv | 24 ++
 rtl/fetch_buf.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_pkg                                                        |
// | Brief    : Shared types for the instruction fetch unit.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mips_pkg;

   localparam int PKG_ADDR_W = 32;
   localparam int PKG_DATA_W = 32;

   typedef struct packed {
      logic [PKG_ADDR_W-1:0] pc;
      logic [PKG_DATA_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_REQ  = 2'd1,
      F_WAIT = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_buf                                                       |
// | Brief    : Synchronous FIFO of {pc, instr} entries with flush.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_buf #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] c_one = (PTR_W+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
         wr_ptr_d = wr_ptr_q + c_one;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + c_one;
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                                |
// | Brief    : Single-outstanding imem fetch with buffered decode handoff.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int BUF_DEPTH = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic              fetch_pc_valid,
   input  logic              redirect,
   output logic              pc_stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic              misalign
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 2;
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(BUF_DEPTH);

   fetch_state_e              state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic                      drop_q, drop_d;
   logic                      misalign_q, misalign_d;

   logic [PTR_W:0]            buf_count;
   logic                      buf_empty, buf_full, buf_push, buf_pop;
   logic [ADDR_W+DATA_W-1:0]  buf_rdata;
   logic [CNT_W-1:0]          slot_count;
   logic                      accept;

   // A fetch in flight already owns a buffer slot, so the buffer can never overflow.
   assign slot_count = CNT_W'(buf_count) + CNT_W'(state_q != F_IDLE);
   assign accept     = (state_q == F_IDLE) && fetch_pc_valid &&
                       (slot_count < c_depth) && !redirect;
   assign pc_stall   = !rst_n || (fetch_pc_valid && !accept);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= F_IDLE;
         addr_q     <= '0;
         drop_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         drop_q     <= drop_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         F_IDLE:  if (accept)      state_d = F_REQ;
         F_REQ:   if (imem_gnt)    state_d = F_WAIT;
         F_WAIT:  if (imem_rvalid) state_d = F_IDLE;
         default:                  state_d = F_IDLE;
      endcase
   end

   // Requests are never withdrawn; a redirect only marks the response for discard.
   always_comb begin
      addr_d     = accept ? {fetch_pc[ADDR_W-1:2], 2'b00} : addr_q;
      misalign_d = misalign_q || (accept && (fetch_pc[1:0] != 2'b00));
      drop_d     = drop_q;
      if (state_q == F_WAIT && imem_rvalid) begin
         drop_d = 1'b0;
      end else if (redirect && state_q != F_IDLE) begin
         drop_d = 1'b1;
      end
   end

   always_comb begin
      imem_req = (state_q == F_REQ);
      buf_push = (state_q == F_WAIT) && imem_rvalid && !drop_q;
      buf_pop  = instr_ready && !buf_empty;
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fetch_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (buf_push),
      .wdata ({addr_q, imem_rdata}),
      .pop   (buf_pop),
      .rdata (buf_rdata),
      .empty (buf_empty),
      .full  (buf_full),
      .count (buf_count)
   );

   assign imem_addr             = addr_q;
   assign instr_valid           = !buf_empty;
   assign {instr_pc, instr}     = buf_rdata;
   assign misalign              = misalign_q;

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(buf_push && buf_full));
   a_rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rvalid && state_q != F_WAIT));
   a_gnt_only_in_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_gnt && state_q != F_REQ));

endmodule
`default_nettype wire
